// File: rtl/count_clusters_pipe.sv
// count_clusters_pipe: pipelined population count of a cluster-flag vector with
// overflow flag, peak-hold and saturating overflow-event statistics.
module count_clusters_pipe #(
  parameter int NVPF     = 1536,
  parameter int IN_FLOPS = 2
) (
  input  logic                         clock4x,
  input  logic                         reset_n,
  input  logic [NVPF-1:0]              vpfs_i,
  input  logic                         valid_i,
  input  logic [$clog2(NVPF+1)-1:0]    thresh_i,
  input  logic                         clear_i,
  output logic [$clog2(NVPF+1)-1:0]    cnt_o,
  output logic                         valid_o,
  output logic                         overflow_o,
  output logic [$clog2(NVPF+1)-1:0]    max_o,
  output logic [15:0]                  ovf_cnt_o
);
  localparam int CW = $clog2(NVPF + 1);
  localparam int NG = (NVPF + 5) / 6;
  localparam int NS = $clog2(NG);
  localparam int L  = IN_FLOPS + NS + 2;
  localparam int PW = 6 * NG;

  function automatic int nodes(input int s);
    return (NG + (1 << s) - 1) >> s;
  endfunction

  function automatic int wid(input int s);
    return (3 + s < CW) ? 3 + s : CW;
  endfunction

  // reset asserts at once and releases on a clock edge
  logic [1:0] rs;
  logic       rst_n;
  always_ff @(posedge clock4x or negedge reset_n)
    if (!reset_n) rs <= '0;
    else rs <= {rs[0], 1'b1};
  assign rst_n = rs[1];

  (* keep = "true" *) logic [NVPF-1:0] in_q [IN_FLOPS];
  logic [L-2:0] vsr;
  always_ff @(posedge clock4x or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < IN_FLOPS; i++) in_q[i] <= '0;
      vsr <= '0;
    end else begin
      in_q[0] <= vpfs_i;
      for (int i = 1; i < IN_FLOPS; i++) in_q[i] <= in_q[i-1];
      vsr <= {vsr[L-3:0], valid_i};
    end

  logic [PW-1:0] pad;
  assign pad = PW'(in_q[IN_FLOPS-1]);

  // level 0 holds 3-bit group counts; each later level sums pairs, odd tail passes alone
  for (genvar s = 0; s <= NS; s++) begin : lv
    localparam int W = wid(s);
    localparam int N = nodes(s);
    localparam int P = (s > 0) ? nodes(s - 1) : 0;
    logic [W-1:0] node [N];
    logic [W-1:0] nxt  [N];
    for (genvar j = 0; j < N; j++) begin : n
      if (s == 0) begin : c
        assign nxt[j] = W'($countones(pad[6*j +: 6]));
      end else if (2 * j + 1 < P) begin : p
        assign nxt[j] = W'(lv[s-1].node[2*j]) + W'(lv[s-1].node[2*j+1]);
      end else begin : o
        assign nxt[j] = W'(lv[s-1].node[2*j]);
      end
    end
    always_ff @(posedge clock4x or negedge rst_n)
      if (!rst_n) for (int j = 0; j < N; j++) node[j] <= '0;
      else node <= nxt;
  end

  logic [CW-1:0] tot;
  logic          vt;
  logic          ov;
  assign tot = CW'(lv[NS].node[0]);
  assign vt  = vsr[L-2];
  assign ov  = vt && (tot > thresh_i);

  always_ff @(posedge clock4x or negedge rst_n)
    if (!rst_n) begin
      valid_o    <= 1'b0;
      overflow_o <= 1'b0;
      cnt_o      <= '0;
      max_o      <= '0;
      ovf_cnt_o  <= '0;
    end else begin
      valid_o    <= vt;
      overflow_o <= ov;
      if (vt) cnt_o <= tot;
      max_o      <= clear_i ? (vt ? tot : '0) : ((vt && tot > max_o) ? tot : max_o);
      ovf_cnt_o  <= clear_i ? 16'(ov) : ovf_cnt_o + 16'(ov && ovf_cnt_o != 16'hFFFF);
    end
endmodule

// File: doc/count_clusters_pipe.md
COUNT_CLUSTERS_PIPE -- requirements
Module: count_clusters_pipe

Interface
REQ-001 The block SHALL have parameter NVPF, default 1536: number of valid-pattern-flag inputs.
REQ-002 The block SHALL have parameter IN_FLOPS, default 2, range 1..4: number of input register stages.
REQ-003 The block SHALL have derived widths: CW = clog2(NVPF+1) (11 at default), NG = ceil(NVPF/6), NS = ceil(log2(NG)).
REQ-004 The block SHALL have port clock4x, input, 1 bit: the only clock, rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port vpfs_i, input, NVPF bits: cluster flags for one sample.
REQ-007 The block SHALL have port valid_i, input, 1 bit: vpfs_i holds a sample to be counted.
REQ-008 The block SHALL have port thresh_i, input, CW bits: overflow threshold, quasi-static.
REQ-009 The block SHALL have port clear_i, input, 1 bit: clears the peak-hold and event-counter statistics.
REQ-010 The block SHALL have port cnt_o, output, CW bits: population count of one sample.
REQ-011 The block SHALL have port valid_o, output, 1 bit: cnt_o and overflow_o are valid this cycle.
REQ-012 The block SHALL have port overflow_o, output, 1 bit: the count exceeded thresh_i.
REQ-013 The block SHALL have port max_o, output, CW bits: the largest valid count since the last clear.
REQ-014 The block SHALL have port ovf_cnt_o, output, 16 bits: number of overflow samples since the last clear, saturating.

Function
REQ-015 The block SHALL pass vpfs_i and valid_i through IN_FLOPS register stages, and synthesis SHALL NOT merge these registers with equivalent registers elsewhere.
REQ-016 The block SHALL zero-pad the flags to 6*NG bits and split them into NG 6-bit groups; each group SHALL be counted by a single-level 6-input count into a 3-bit value in one registered stage.
REQ-017 The block SHALL reduce the group counts with a registered binary adder tree of NS stages; odd or missing operands SHALL be zero, and each stage's width SHALL grow by 1 bit, capped at CW.
REQ-018 The block SHALL have a total latency L = IN_FLOPS + NS + 2 cycles from valid_i to valid_o (12 at defaults); valid SHALL travel in a shift register that matches the data pipeline.
REQ-019 The block SHALL accept a new sample every cycle with no stall; samples with valid_i=0 SHALL produce valid_o=0 in their slot.
REQ-020 The block SHALL assert cnt_o as the exact count, at most NVPF, in the cycle valid_o=1; when valid_o=0, cnt_o SHALL hold its last valid value.
REQ-021 The block SHALL drive overflow_o = valid_o AND (count > thresh_i), where thresh_i is sampled in the output-stage cycle; count equal to thresh_i SHALL NOT overflow.
REQ-022 The block SHALL update max_o on each valid output to max(max_o, count); if clear_i is high in the same cycle, max_o SHALL take the current valid count, otherwise 0.
REQ-023 The block SHALL increment ovf_cnt_o by 1 for each overflow_o=1 cycle and saturate it at 0xFFFF; clear_i together with an overflow SHALL load 1, and clear_i alone SHALL load 0.
REQ-024 The block SHALL leave in-flight data unaffected by clear_i.

Reset
REQ-025 On reset_n=0, the block SHALL asynchronously clear all valid-pipe bits, cnt_o, valid_o, overflow_o, max_o and ovf_cnt_o to 0.
REQ-026 The block SHALL clear the data pipeline registers to 0 on reset.
REQ-027 The block SHALL release reset synchronously to clock4x.
REQ-028 The block SHALL discard samples in flight when reset is asserted mid-operation; valid_o SHALL stay 0 until L cycles after the first valid_i following deassertion.

Verification
REQ-029 A bench SHALL cover: all-zero vpfs_i with valid_i=1 -> cnt_o=0, valid_o=1 exactly 12 cycles later, overflow_o=0.
REQ-030 A bench SHALL cover: all-ones vpfs_i, thresh_i=8 -> cnt_o=1536, overflow_o=1, max_o=1536, ovf_cnt_o=1.
REQ-031 A bench SHALL cover: back-to-back samples of 8, 9, 0 bits, thresh_i=8 -> consecutive cnt_o 8, 9, 0; overflow_o 0, 1, 0; max_o=9.
REQ-032 A bench SHALL cover: a random stream with valid_i toggling -> every cnt_o matches the reference popcount and valid_o matches valid_i delayed by 12.
REQ-033 A bench SHALL cover: clear_i coinciding with a valid count of 20 above thresh_i=8 -> max_o=20, ovf_cnt_o=1; 70000 overflow samples -> ovf_cnt_o=0xFFFF.
REQ-034 A bench SHALL cover: reset_n pulsed low with 5 samples in flight -> outputs 0 at once and no stale valid_o afterwards; NVPF=100 run -> all-ones gives cnt_o=100.
